// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one CLR/INCR-controlled timer among REQ_NUM requesters.
// Grants are round-robin. The owner's target is compared against the live count,
// and a one-cycle done pulse goes to the owner when the count reaches the target.
module timer_arbiter #(
    parameter int unsigned REQ_NUM     = 4,
    parameter int unsigned TIMER_WIDTH = 28,
    parameter int unsigned CTRL_WIDTH  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_NUM-1:0]             req,
    input  logic [REQ_NUM*TIMER_WIDTH-1:0] req_ticks,
    input  logic                           flush,
    input  logic [TIMER_WIDTH-1:0]         timer_input,
    output logic [CTRL_WIDTH-1:0]          timer_ctrl,
    output logic [REQ_NUM-1:0]             grant,
    output logic [REQ_NUM-1:0]             done,
    output logic                           busy
);

    localparam int unsigned IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    localparam logic [CTRL_WIDTH-1:0] CTRL_NONE = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_CLR  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CTRL_INCR = CTRL_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [TIMER_WIDTH-1:0] target_q, target_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic                   win_valid;
    logic [IDX_W-1:0]       win_idx;
    logic [REQ_NUM-1:0]     owner_oh;
    logic                   owner_req;

    // Round-robin pick: first set request scanning ptr+1, ptr+2, ... (mod REQ_NUM).
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = REQ_NUM; k >= 1; k--) begin
            int unsigned cand;
            cand = (int'(ptr_q) + k) % REQ_NUM;
            if (req[IDX_W'(cand)]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign owner_oh  = REQ_NUM'(1) << owner_q;
    assign owner_req = req[owner_q];

    // Next-state and output decode; flush and reset override the per-state result.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        target_d   = target_q;
        ptr_d      = ptr_q;
        timer_ctrl = CTRL_NONE;
        grant      = '0;
        done       = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    owner_d  = win_idx;
                    target_d = req_ticks[win_idx*TIMER_WIDTH +: TIMER_WIDTH];
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                grant      = owner_oh;
                timer_ctrl = CTRL_CLR;
                if (!owner_req) begin
                    ptr_d   = owner_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                grant = owner_oh;
                if (!owner_req) begin
                    timer_ctrl = CTRL_CLR;
                    ptr_d      = owner_q;
                    state_d    = ST_IDLE;
                end else if (timer_input == target_q) begin
                    done       = owner_oh;
                    timer_ctrl = CTRL_CLR;
                    ptr_d      = owner_q;
                    state_d    = ST_IDLE;
                end else begin
                    timer_ctrl = CTRL_INCR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            timer_ctrl = CTRL_CLR;
            grant      = '0;
            done       = '0;
            owner_d    = owner_q;
            target_d   = target_q;
            state_d    = ST_IDLE;
            ptr_d      = (state_q != ST_IDLE) ? owner_q : ptr_q;
        end

        if (rst) begin
            timer_ctrl = CTRL_CLR;
            grant      = '0;
            done       = '0;
        end
    end

    assign busy = |grant;

    // State, owner, target and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            target_q <= '0;
            ptr_q    <= IDX_W'(REQ_NUM - 1);
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Testbench for timer_arbiter: models the shared timer and checks every cycle
// against a transaction-level reference (owner, elapsed cycles, rr pointer).
module tb_timer_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 28;
    localparam int unsigned CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    req = '0;
    logic [TW-1:0]   ticks [N];
    logic [N*TW-1:0] req_ticks;
    logic [TW-1:0]   tb_timer = '0;
    logic [CW-1:0]   timer_ctrl;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    int            m_owner = -1;
    int            m_age   = 0;
    int            m_ptr   = N - 1;
    logic [TW-1:0] m_target = '0;

    // last sampled DUT outputs
    int s_ctrl, s_grant, s_done, s_busy;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_ticks[i*TW +: TW] = ticks[i];
    end

    timer_arbiter #(.REQ_NUM(N), .TIMER_WIDTH(TW), .CTRL_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_ticks  (req_ticks),
        .flush      (flush),
        .timer_input(tb_timer),
        .timer_ctrl (timer_ctrl),
        .grant      (grant),
        .done       (done),
        .busy       (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One clock: sample/compare at negedge, then advance model and timer after posedge.
    task automatic step();
        int e_ctrl, e_grant, e_done, n_owner, n_age, n_ptr, win;
        logic [TW-1:0] n_target;
        @(negedge clk);
        e_ctrl = 0; e_grant = 0; e_done = 0;
        n_owner = m_owner; n_age = m_age; n_ptr = m_ptr; n_target = m_target;
        if (rst) begin
            e_ctrl = 1; n_owner = -1; n_ptr = N - 1;
        end else if (flush) begin
            e_ctrl = 1;
            if (m_owner >= 0) n_ptr = m_owner;
            n_owner = -1;
        end else if (m_owner < 0) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req[i] && win < 0) win = i;
            end
            if (win >= 0) begin
                n_owner = win; n_target = ticks[win]; n_age = 0;
            end
        end else begin
            e_grant = 1 << m_owner;
            if (!req[m_owner]) begin
                e_ctrl = 1; n_ptr = m_owner; n_owner = -1;
            end else if (m_age == 0) begin
                e_ctrl = 1; n_age = 1;
            end else if (m_age - 1 == int'(m_target)) begin
                e_ctrl = 1; e_done = e_grant; n_ptr = m_owner; n_owner = -1;
            end else begin
                e_ctrl = 3; n_age = m_age + 1;
            end
        end
        s_ctrl = int'(timer_ctrl); s_grant = int'(grant);
        s_done = int'(done);       s_busy  = int'(busy);
        chk("timer_ctrl", s_ctrl, e_ctrl);
        chk("grant", s_grant, e_grant);
        chk("done", s_done, e_done);
        chk("busy", s_busy, (e_grant != 0) ? 1 : 0);
        @(posedge clk);
        #1;
        m_owner = n_owner; m_age = n_age; m_ptr = n_ptr; m_target = n_target;
        if (s_ctrl == 1) tb_timer = '0;
        else if (s_ctrl == 3) tb_timer = tb_timer + TW'(1);
        cyc++;
    endtask

    initial begin
        int order[$];
        int bound;
        for (int i = 0; i < N; i++) ticks[i] = '0;

        // reset with all requests pending, then req[0] wins first
        req = 4'b1111;
        step(); chk("rst_ctrl0", s_ctrl, 1); chk("rst_grant0", s_grant, 0);
        step(); chk("rst_ctrl1", s_ctrl, 1); chk("rst_grant1", s_grant, 0);
        rst = 1'b0;
        step(); chk("rel_c0_grant", s_grant, 0);
        step(); chk("rel_c1_grant", s_grant, 1);
        step(); chk("rel_c2_done", s_done, 1);
        req = '0;
        step();

        // single delay of 5 ticks on requester 2
        req = 4'b0100; ticks[2] = 28'd5;
        step();
        step(); chk("single_c1_ctrl", s_ctrl, 1); chk("single_c1_grant", s_grant, 4);
        for (int c = 2; c <= 6; c++) begin
            step(); chk("single_incr", s_ctrl, 3);
        end
        step(); chk("single_c7_done", s_done, 4); chk("single_c7_ctrl", s_ctrl, 1);
        req = '0; ticks[2] = '0;
        step(); chk("single_c8_busy", s_busy, 0);

        // round robin with zero-tick delays
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1011;
        bound = 0;
        while (order.size() < 3 && bound < 40) begin
            step();
            if (s_done != 0) begin
                for (int i = 0; i < N; i++) if (s_done[i]) order.push_back(i);
                req = req & ~N'(s_done);
            end
            bound++;
        end
        chk("rr_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("rr_first", order[0], 0);
            chk("rr_second", order[1], 1);
            chk("rr_third", order[2], 3);
        end
        req = '0; step();
        req = 4'b0001;
        step(); step(); chk("rr_reassert_grant", s_grant, 1);
        step(); chk("rr_reassert_done", s_done, 1);
        req = '0; step();

        // withdrawal after 9 counting cycles
        req = 4'b0010; ticks[1] = 28'd100;
        step(); step();
        for (int c = 0; c < 9; c++) step();
        req = '0;
        step(); chk("wd_ctrl", s_ctrl, 1); chk("wd_done", s_done, 0);
        step(); chk("wd_busy", s_busy, 0); chk("wd_grant", s_grant, 0);

        // flush on the matching cycle
        req = 4'b0001; ticks[0] = 28'd3;
        step(); step();
        for (int c = 0; c < 3; c++) step();
        chk("flush_pre_timer", int'(tb_timer), 3);
        flush = 1'b1;
        step(); chk("flush_ctrl", s_ctrl, 1); chk("flush_done", s_done, 0); chk("flush_grant", s_grant, 0);
        flush = 1'b0; req = '0;
        step();

        // synchronous reset mid-count
        req = 4'b0001; ticks[0] = 28'd100;
        step(); step();
        bound = 0;
        while (tb_timer != 28'd40 && bound < 60) begin step(); bound++; end
        chk("rst_mid_reached", int'(tb_timer), 40);
        rst = 1'b1;
        step(); chk("rst_mid_ctrl", s_ctrl, 1); chk("rst_mid_grant", s_grant, 0); chk("rst_mid_done", s_done, 0);
        rst = 1'b0; req = '0;
        step(); chk("rst_mid_after_grant", s_grant, 0);

        // ticks changed after sampling do not affect the running delay
        req = 4'b1000; ticks[3] = 28'd8;
        step();
        ticks[3] = 28'd2;
        step();
        for (int c = 2; c <= 9; c++) begin
            step(); chk("tchg_no_done", s_done, 0);
        end
        step(); chk("tchg_c10_done", s_done, 8);
        req = '0; step();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < N; i++) begin
                if (s_done[i]) req[i] = 1'b0;
                else if (i == m_owner) req[i] = ($urandom_range(0, 99) < 98);
                else if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 7) == 0)
                    ticks[i] = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(0, 15));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
